fir_tcdm_responder: RTL and testbench
=====================================

Name: fir_tcdm_responder

Overview:
- TCDM/HCI-core slave-side responder: answers the memory requests issued by the FIR streamer's x/h sources and y sink.
- Holds a word-addressed backing store, a programmable fixed read latency, and pseudo-random grant stalls.
- Used as the memory end of the FIR HWPE in block-level benches and FPGA bring-up; one instance per streamer master port.

Parameters:
- DW, 32, data width in bits (multiple of 8).
- DEPTH, 1024, words in the backing store (power of 2).
- LATENCY, 1, cycles from grant to r_valid (1..4).
- STALL_EN, 1, 1 enables pseudo-random grant stalls.
- LFSR_SEED, 16'hACE1, non-zero reset value of the stall LFSR.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of pipeline, LFSR and error flag; memory contents kept
- stall_thr_i  in  16  stall threshold; a cycle stalls when lfsr < stall_thr_i (0 = never)
- req_i  in  1  request
- gnt_o  out  1  grant (combinational)
- add_i  in  32  byte address
- wen_i  in  1  1 = read, 0 = write
- be_i  in  DW/8  byte enables
- data_i  in  DW  write data
- r_data_o  out  DW  read data
- r_valid_o  out  1  response valid
- err_o  out  1  sticky out-of-range flag

Behaviour:
- Reset values: gnt_o=0, r_valid_o=0, r_data_o=0, err_o=0, lfsr=LFSR_SEED, ready_q=0.
- ready_q rises 1 cycle after reset release. gnt_o = req_i & ready_q & ~stall.
- stall = STALL_EN & (lfsr < stall_thr_i).
- The LFSR is 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle while ready_q=1 and holds otherwise.
- Handshake: a transaction fires on req_i & gnt_o.
  - Master holds add/wen/be/data stable until granted.
  - A stalled request produces no side effect.
- Index = add_i[log2(DEPTH)+1:2]. Low two address bits are ignored.
- Out of range: if any address bit above the index range is set, err_o sets and stays set. The access still wraps onto the index.
- Write: bytes with be_i set are updated at the firing edge; other bytes are unchanged; be_i=0 is a no-op write.
- Read: data is sampled at the firing edge and reflects all previously fired writes. This includes a write fired on the immediately preceding cycle.
- Response pipeline: LATENCY-stage shift register of {valid, data}.
  - Every fired transaction, read or write, returns exactly one r_valid_o pulse, exactly LATENCY cycles after its firing edge.
  - Writes return r_data_o=0.
  - Responses are strictly in order. Back-to-back fires give back-to-back r_valid_o; throughput is 1 transaction per cycle.
  - r_data_o is held at its last value when r_valid_o=0.
  - There is no r_ready; the master must always accept responses.
- clear_i:
  - Flushes all in-flight responses; no r_valid_o is issued for them.
  - Reloads LFSR_SEED and clears err_o.
  - Forces gnt_o=0 in that cycle.
  - Memory is not modified.
- Reset asserted mid-transaction: all in-flight responses are lost and outputs return to reset values immediately. Memory contents are undefined after reset.
- stall_thr_i may change at any time; it takes effect in the same cycle.

Decomposition:
- fir_package additions:
  - FIR_TCDM_LFSR_W=16 and FIR_TCDM_LFSR_TAPS.
  - typedef fir_tcdm_resp_t {logic valid; logic [DW-1:0] data;} for pipeline stages.
- Sub-module fir_tcdm_stall_gen: LFSR plus threshold compare.
  - Inputs: clk_i, rst_ni, clear_i, en_i, thr_i.
  - Output: stall_o.
- Reused unchanged in other HWPE benches.

Test Plan:
- Write then read, no stalls, LATENCY=1, stall_thr=0:
  - Write 32'hDEADBEEF to add 0x10 with be=4'hF, then read 0x10.
  - gnt_o=1 both cycles; r_valid_o at cycles +1 and +2; second r_data_o=32'hDEADBEEF.
- Byte enables:
  - Write 32'h11223344 at 0x20, then 32'hAABBCCDD with be=4'b0101, then read 0x20.
  - r_data_o=32'h11BB33DD.
- Stall injection, stall_thr=16'h8000, 1000 reads:
  - r_valid_o count equals grant count.
  - Stall rate is between 40% and 60%.
  - No response without a prior grant.
- Latency and in-order, LATENCY=3:
  - 8 back-to-back reads of preloaded values 0..7.
  - r_valid_o high 8 consecutive cycles starting 3 cycles after the first grant; data 0..7 in order.
- Clear and out of range, LATENCY=3:
  - Issue 2 reads, pulse clear_i 1 cycle later: no r_valid_o follows.
  - Access add 32'h0000_1000 with DEPTH=1024: err_o=1, wrapping to index 0; the next clear_i resets err_o=0.
- Reset behaviour:
  - During reset and for 1 cycle after release, gnt_o=0 with req_i=1.
  - Reset asserted mid-burst: r_valid_o drops to 0 immediately.

Source files
------------

// File: rtl/fir_tcdm_responder_pkg.sv
// Shared constants and helpers for the FIR TCDM responder and its stall generator.
// The LFSR is a 16-bit right-shifting Fibonacci register with taps 16,14,13,11.
package fir_tcdm_responder_pkg;

  localparam int unsigned FIR_TCDM_LFSR_W = 16;
  localparam int unsigned FIR_TCDM_AW     = 32;

  // Tap mask in right-shift form: polynomial taps 16,14,13,11 map to bits 0,2,3,5.
  localparam logic [FIR_TCDM_LFSR_W-1:0] FIR_TCDM_LFSR_TAPS = 16'h002D;

  function automatic logic [FIR_TCDM_LFSR_W-1:0] fir_tcdm_lfsr_next(
    input logic [FIR_TCDM_LFSR_W-1:0] state
  );
    return {^(state & FIR_TCDM_LFSR_TAPS), state[FIR_TCDM_LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/fir_tcdm_stall_gen.sv
// Pseudo-random grant stall source: free-running LFSR compared against a threshold.
// A cycle stalls when the current LFSR value is below thr_i; thr_i = 0 never stalls.
module fir_tcdm_stall_gen
  import fir_tcdm_responder_pkg::*;
#(
  parameter bit                         STALL_EN  = 1'b1,
  parameter logic [FIR_TCDM_LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       en_i,
  input  logic [FIR_TCDM_LFSR_W-1:0] thr_i,
  output logic                       stall_o
);

  logic [FIR_TCDM_LFSR_W-1:0] lfsr_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else if (clear_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_i) begin
      lfsr_q <= fir_tcdm_lfsr_next(lfsr_q);
    end
  end

  assign stall_o = STALL_EN && (lfsr_q < thr_i);

endmodule

// File: rtl/fir_tcdm_responder.sv
// TCDM slave-side responder: word-addressed backing store, fixed read latency,
// pseudo-random grant stalls and a sticky out-of-range flag.
module fir_tcdm_responder
  import fir_tcdm_responder_pkg::*;
#(
  parameter int unsigned                DW        = 32,
  parameter int unsigned                DEPTH     = 1024,
  parameter int unsigned                LATENCY   = 1,
  parameter bit                         STALL_EN  = 1'b1,
  parameter logic [FIR_TCDM_LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [FIR_TCDM_LFSR_W-1:0] stall_thr_i,
  input  logic                       req_i,
  output logic                       gnt_o,
  input  logic [FIR_TCDM_AW-1:0]     add_i,
  input  logic                       wen_i,
  input  logic [DW/8-1:0]            be_i,
  input  logic [DW-1:0]              data_i,
  output logic [DW-1:0]              r_data_o,
  output logic                       r_valid_o,
  output logic                       err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BW    = DW / 8;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
  } fir_tcdm_resp_t;

  logic                 ready_q;
  logic                 stall;
  logic                 fire;
  logic                 out_of_range;
  logic [IDX_W-1:0]     idx;
  logic [DW-1:0]        rd_data;
  logic [DW-1:0]        mem [DEPTH];
  fir_tcdm_resp_t       resp_q [LATENCY];
  logic                 err_q;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^add_i[1:0];

  assign idx          = add_i[IDX_W+1:2];
  assign out_of_range = |add_i[FIR_TCDM_AW-1:IDX_W+2];

  // Grant is combinational so a request can fire in the cycle it is raised.
  assign gnt_o = req_i & ready_q & ~stall & ~clear_i;
  assign fire  = req_i & gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  fir_tcdm_stall_gen #(
    .STALL_EN  (STALL_EN),
    .LFSR_SEED (LFSR_SEED)
  ) i_stall_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (ready_q),
    .thr_i   (stall_thr_i),
    .stall_o (stall)
  );

  // NOTE: the backing store has no reset; its contents are undefined after rst_ni.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BW; b++) begin
      if (fire && !wen_i && be_i[b]) begin
        mem[idx][b*8 +: 8] <= data_i[b*8 +: 8];
      end
    end
  end

  // Read data is taken from the array before this edge's write lands, so a
  // write fired one cycle earlier is already visible.
  assign rd_data = wen_i ? mem[idx] : '0;

  // Data in each stage only moves with a valid entry, so r_data_o holds its
  // last response across idle cycles and clears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < LATENCY; k++) begin
        resp_q[k] <= '0;
      end
    end else if (clear_i) begin
      for (int k = 0; k < LATENCY; k++) begin
        resp_q[k].valid <= 1'b0;
      end
    end else begin
      resp_q[0].valid <= fire;
      if (fire) begin
        resp_q[0].data <= rd_data;
      end
      for (int k = 1; k < LATENCY; k++) begin
        resp_q[k].valid <= resp_q[k-1].valid;
        if (resp_q[k-1].valid) begin
          resp_q[k].data <= resp_q[k-1].data;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clear_i) begin
      err_q <= 1'b0;
    end else if (fire && out_of_range) begin
      err_q <= 1'b1;
    end
  end

  assign r_valid_o = resp_q[LATENCY-1].valid;
  assign r_data_o  = resp_q[LATENCY-1].data;
  assign err_o     = err_q;

endmodule

// File: tb/tb_fir_tcdm_responder.sv
// Directed bench for fir_tcdm_responder: LATENCY=1 and LATENCY=3 instances share
// stimulus; a memory/LFSR model predicts grants and a scoreboard checks responses.
module tb_fir_tcdm_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] thr;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        gnt1, rv1, err1;
  logic [31:0] rdata1;
  logic        gnt3, rv3, err3;
  logic [31:0] rdata3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_resp1 = 0;
  int n_resp3 = 0;
  int n_fires = 0;
  int n_stall = 0;
  logic [31:0] last_rdata1, last_rdata3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  logic [31:0] ref_mem [1024];
  logic [15:0] m_lfsr;
  logic        m_ready;

  fir_tcdm_responder #(.DW(32), .DEPTH(1024), .LATENCY(1), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_thr_i(thr),
    .req_i(req), .gnt_o(gnt1), .add_i(add), .wen_i(wen), .be_i(be), .data_i(wdata),
    .r_data_o(rdata1), .r_valid_o(rv1), .err_o(err1)
  );

  fir_tcdm_responder #(.DW(32), .DEPTH(1024), .LATENCY(3), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_thr_i(thr),
    .req_i(req), .gnt_o(gnt3), .add_i(add), .wen_i(wen), .be_i(be), .data_i(wdata),
    .r_data_o(rdata3), .r_valid_o(rv3), .err_o(err3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference LFSR: bits 0,2,3,5 are taps 16,14,13,11 of the shift-right form.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr  <= 16'hACE1;
      m_ready <= 1'b0;
    end else begin
      m_ready <= 1'b1;
      if (clear) m_lfsr <= 16'hACE1;
      else if (m_ready) m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_gnt();
    return req && m_ready && !clear && !(m_lfsr < thr);
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rv1) begin
        n_resp1++;
        last_rdata1 = rdata1;
        if (q1.size() == 0) check("spurious_rv1", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          check("rdata1", rdata1, e1.data);
          check("lat1", cyc, e1.cyc + 1);
        end
      end
      if (rv3) begin
        n_resp3++;
        last_rdata3 = rdata3;
        if (q3.size() == 0) check("spurious_rv3", 32'd1, 32'd0);
        else begin
          e3 = q3.pop_front();
          check("rdata3", rdata3, e3.data);
          check("lat3", cyc, e3.cyc + 3);
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that fired, req still high.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [9:0]  i;
    logic [31:0] exp_d;
    bit          done;
    req = 1'b1; wen = w; add = a; be = b; wdata = d;
    done = 0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      check("gnt1", gnt1, exp_gnt());
      check("gnt3", gnt3, exp_gnt());
      if (gnt1) begin
        i = a[11:2];
        exp_d = w ? ref_mem[i] : 32'h0;
        q1.push_back('{exp_d, cyc});
        q3.push_back('{exp_d, cyc});
        if (!w) for (int k = 0; k < 4; k++) if (b[k]) ref_mem[i][k*8 +: 8] = d[k*8 +: 8];
        n_fires++;
        done = 1;
      end else begin
        n_stall++;
      end
      @(posedge clk); #1;
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    req = 1'b0;
    for (int n = 0; n < 40 && (q1.size() != 0 || q3.size() != 0); n++) @(negedge clk);
    @(posedge clk); #1;
    check("drain_q1", q1.size(), 32'd0);
    check("drain_q3", q3.size(), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h0;
    @(negedge clk);
    check("gnt_clear", gnt1, 32'd0);
    while (q1.size() > 0 && q1[$].cyc + 1 > cyc) void'(q1.pop_back());
    while (q3.size() > 0 && q3[$].cyc + 3 > cyc) void'(q3.pop_back());
    @(posedge clk); #1;
    clear = 1'b0; req = 1'b0;
  endtask

  initial begin
    int r1, r3, f0, s0;
    rst_n = 1'b0; clear = 1'b0; thr = 16'h0; req = 1'b1;
    add = 32'h0; wen = 1'b1; be = 4'hF; wdata = 32'h0;

    // Reset: grant withheld during reset and for one cycle after release.
    repeat (2) @(negedge clk);
    check("gnt_in_reset", gnt1, 32'd0);
    check("rv_in_reset", rv1, 32'd0);
    check("rdata_in_reset", rdata3, 32'd0);
    check("err_in_reset", err1, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("gnt_after_release", gnt1, 32'd0);
    @(negedge clk);
    check("gnt_ready", gnt1, 32'd1);
    req = 1'b0;
    @(posedge clk); #1;

    // Write then read, LATENCY=1 response follows each fire by one cycle.
    access(1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
    access(1'b1, 32'h10, 4'hF, 32'h0);
    drain();
    check("wr_rd_data", last_rdata1, 32'hDEADBEEF);

    // Byte enables.
    access(1'b0, 32'h20, 4'hF, 32'h11223344);
    access(1'b0, 32'h20, 4'b0101, 32'hAABBCCDD);
    access(1'b1, 32'h20, 4'hF, 32'h0);
    drain();
    check("be_data", last_rdata3, 32'h11BB33DD);

    // LATENCY=3: preload 0..7 then 8 back-to-back reads.
    for (int i = 0; i < 8; i++) access(1'b0, i * 4, 4'hF, i);
    drain();
    r3 = n_resp3;
    for (int i = 0; i < 8; i++) access(1'b1, i * 4, 4'hF, 32'h0);
    drain();
    check("lat3_count", n_resp3 - r3, 32'd8);
    check("lat3_last", last_rdata3, 32'd7);

    // Clear flushes in-flight LATENCY=3 responses.
    access(1'b1, 32'h4, 4'hF, 32'h0);
    access(1'b1, 32'h8, 4'hF, 32'h0);
    r3 = n_resp3;
    pulse_clear();
    repeat (6) @(posedge clk); #1;
    check("clear_no_rv3", n_resp3 - r3, 32'd0);
    check("clear_q3", q3.size(), 32'd0);

    // Out of range: wraps to index 0 and sets the sticky flag until clear.
    check("err_before", err1, 32'd0);
    access(1'b0, 32'h0000_1000, 4'hF, 32'hCAFE0001);
    check("err1_set", err1, 32'd1);
    check("err3_set", err3, 32'd1);
    access(1'b1, 32'h0, 4'hF, 32'h0);
    drain();
    check("oor_wrap", last_rdata1, 32'hCAFE0001);
    check("err_sticky", err1, 32'd1);
    pulse_clear();
    check("err1_cleared", err1, 32'd0);
    check("err3_cleared", err3, 32'd0);

    // Stall injection.
    thr = 16'h8000;
    r1 = n_resp1; f0 = n_fires; s0 = n_stall;
    for (int i = 0; i < 1000; i++) access(1'b1, $urandom_range(0, 7) * 4, 4'hF, 32'h0);
    req = 1'b0; thr = 16'h0;
    drain();
    check("stall_resp_eq_gnt", n_resp1 - r1, n_fires - f0);
    check("stall_rate", ((n_stall - s0) * 100 >= 40 * (n_stall - s0 + n_fires - f0)) &&
                        ((n_stall - s0) * 100 <= 60 * (n_stall - s0 + n_fires - f0)), 32'd1);

    // Reset mid-burst drops r_valid_o immediately.
    for (int i = 0; i < 4; i++) access(1'b1, i * 4, 4'hF, 32'h0);
    check("rv3_before_reset", rv3, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rv1_reset", rv1, 32'd0);
    check("rv3_reset", rv3, 32'd0);
    check("rdata3_reset", rdata3, 32'd0);
    check("gnt_reset", gnt1, 32'd0);
    q1.delete(); q3.delete();
    req = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
